// File: rtl/fm_discriminator.sv
// Time-interleaved FM phase discriminator: per-channel phase difference with
// wrap-around, optional gain shift or phase bypass, AXI-Stream in and out.
module fm_discriminator #(
    parameter int ANGLE_W    = 16,
    parameter int NUM_CH     = 4,
    parameter int GAIN_SHIFT = 1
) (
    input  logic        s00_axis_aclk,
    input  logic        s00_axis_aresetn,
    input  logic        s00_axis_tvalid,
    output logic        s00_axis_tready,
    input  logic [31:0] s00_axis_tdata,
    input  logic        s00_axis_tlast,
    input  logic [3:0]  s00_axis_tstrb,
    input  logic [1:0]  mode,
    input  logic        hist_clear,
    output logic        m00_axis_tvalid,
    input  logic        m00_axis_tready,
    output logic [31:0] m00_axis_tdata,
    output logic        m00_axis_tlast,
    output logic [3:0]  m00_axis_tstrb
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

    logic                      accept_s;
    logic [ANGLE_W-1:0]        phase_s;
    logic [ANGLE_W-1:0]        prev_s;
    logic [ANGLE_W-1:0]        diff_s;
    logic signed [ANGLE_W-1:0] scaled_s;
    logic                      unprimed_s;
    logic [15:0]               result_s;
    logic [CH_W-1:0]           ch_r;
    logic [CH_W-1:0]           ch_next_s;
    logic [NUM_CH-1:0]         primed_r;
    logic [NUM_CH-1:0]         primed_next_s;
    logic [ANGLE_W-1:0]        prev_phase_r [NUM_CH];
    logic                      unused_tdata_s;

    assign s00_axis_tready = m00_axis_tready | ~m00_axis_tvalid;
    assign accept_s        = s00_axis_tvalid & s00_axis_tready;
    assign phase_s         = s00_axis_tdata[31 -: ANGLE_W];
    assign unused_tdata_s  = ^s00_axis_tdata[31-ANGLE_W:0];

    // Datapath: modular difference against the channel history, then mode select
    always_comb begin
        prev_s     = prev_phase_r[ch_r];
        diff_s     = phase_s - prev_s;
        scaled_s   = $signed(diff_s) >>> GAIN_SHIFT;
        // A coincident history clear makes this beat behave as the first one.
        unprimed_s = ~primed_r[ch_r] | hist_clear;
        case (mode)
            2'd1: begin
                if (unprimed_s) begin
                    result_s = 16'h0000;
                end else begin
                    result_s = 16'(scaled_s);
                end
            end
            2'd2: begin
                result_s = 16'(phase_s);
            end
            default: begin
                if (unprimed_s) begin
                    result_s = 16'h0000;
                end else begin
                    result_s = 16'($signed(diff_s));
                end
            end
        endcase
    end

    // Next channel index and next primed vector
    always_comb begin
        if (s00_axis_tlast || (ch_r == CH_LAST)) begin
            ch_next_s = '0;
        end else begin
            ch_next_s = ch_r + CH_W'(1);
        end
        if (hist_clear) begin
            primed_next_s = '0;
        end else begin
            primed_next_s = primed_r;
        end
        if (accept_s) begin
            primed_next_s[ch_r] = 1'b1;
        end else begin
            primed_next_s[ch_r] = primed_next_s[ch_r];
        end
    end

    // Channel counter, primed flags and per-channel phase history
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            ch_r     <= '0;
            primed_r <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                prev_phase_r[i] <= '0;
            end
        end else begin
            primed_r <= primed_next_s;
            if (accept_s) begin
                ch_r               <= ch_next_s;
                prev_phase_r[ch_r] <= phase_s;
            end
        end
    end

    // Output register stage: load on accept, retire on downstream ready, else hold
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            m00_axis_tvalid <= 1'b0;
            m00_axis_tdata  <= 32'h0000_0000;
            m00_axis_tlast  <= 1'b0;
            m00_axis_tstrb  <= 4'h0;
        end else if (accept_s) begin
            m00_axis_tvalid <= 1'b1;
            m00_axis_tdata  <= {8'h00, 8'(ch_r), result_s};
            m00_axis_tlast  <= s00_axis_tlast;
            m00_axis_tstrb  <= s00_axis_tstrb;
        end else if (m00_axis_tready) begin
            m00_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fm_discriminator.sv
// Directed bench for fm_discriminator (ANGLE_W=16, NUM_CH=2, GAIN_SHIFT=1):
// hand-computed expected words for each beat, backpressure and async reset.
module tb_fm_discriminator;

    logic        clk;
    logic        rst_n;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic [3:0]  s_tstrb;
    logic [1:0]  mode;
    logic        hist_clear;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic [3:0]  m_tstrb;

    int n_checks;
    int n_pass;

    fm_discriminator #(
        .ANGLE_W    (16),
        .NUM_CH     (2),
        .GAIN_SHIFT (1)
    ) dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst_n),
        .s00_axis_tvalid  (s_tvalid),
        .s00_axis_tready  (s_tready),
        .s00_axis_tdata   (s_tdata),
        .s00_axis_tlast   (s_tlast),
        .s00_axis_tstrb   (s_tstrb),
        .mode             (mode),
        .hist_clear       (hist_clear),
        .m00_axis_tvalid  (m_tvalid),
        .m00_axis_tready  (m_tready),
        .m00_axis_tdata   (m_tdata),
        .m00_axis_tlast   (m_tlast),
        .m00_axis_tstrb   (m_tstrb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One accepted beat with the sink ready; checks the registered result one edge later.
    task automatic send(input string tag, input logic [15:0] ph, input logic [1:0] md,
                        input logic last, input logic clr, input logic [3:0] strb,
                        input logic [31:0] exp);
        @(negedge clk);
        s_tvalid   = 1'b1;
        s_tdata    = {ph, 16'hA5C3};
        mode       = md;
        s_tlast    = last;
        hist_clear = clr;
        s_tstrb    = strb;
        m_tready   = 1'b1;
        @(posedge clk);
        #1;
        s_tvalid   = 1'b0;
        s_tlast    = 1'b0;
        hist_clear = 1'b0;
        check_val({tag, ".data"}, m_tdata, exp);
        check_val({tag, ".valid"}, {31'd0, m_tvalid}, 32'd1);
        check_val({tag, ".last"}, {31'd0, m_tlast}, {31'd0, last});
        check_val({tag, ".strb"}, {28'd0, m_tstrb}, {28'd0, strb});
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        rst_n      = 1'b0;
        s_tvalid   = 1'b0;
        s_tdata    = 32'h0000_0000;
        s_tlast    = 1'b0;
        s_tstrb    = 4'h0;
        mode       = 2'd0;
        hist_clear = 1'b0;
        m_tready   = 1'b1;

        repeat (2) @(negedge clk);
        check_val("rst.valid", {31'd0, m_tvalid}, 32'd0);
        check_val("rst.data", m_tdata, 32'h0000_0000);
        check_val("rst.last_strb", {27'd0, m_tlast, m_tstrb}, 32'd0);
        check_val("rst.s_ready", {31'd0, s_tready}, 32'd1);
        rst_n = 1'b1;

        send("b01_ch0_first", 16'h1000, 2'd0, 1'b0, 1'b0, 4'hF, 32'h0000_0000);
        send("b02_ch1_first", 16'h5000, 2'd0, 1'b0, 1'b0, 4'hF, 32'h0001_0000);
        send("b03_ch0_diff",  16'h1100, 2'd0, 1'b0, 1'b0, 4'hF, 32'h0000_0100);
        send("b04_ch1_neg",   16'h2000, 2'd0, 1'b0, 1'b0, 4'hF, 32'h0001_D000);
        send("b05_ch0_big",   16'h7FF0, 2'd0, 1'b0, 1'b0, 4'hF, 32'h0000_6EF0);
        send("b06_ch1_scale", 16'h1F00, 2'd1, 1'b0, 1'b0, 4'hF, 32'h0001_FF80);
        send("b07_ch0_wrapp", 16'h8010, 2'd0, 1'b0, 1'b0, 4'hF, 32'h0000_0020);
        send("b08_ch1_diff",  16'h0010, 2'd0, 1'b0, 1'b0, 4'hF, 32'h0001_E110);
        send("b09_ch0_bypas", 16'hABCD, 2'd2, 1'b0, 1'b0, 4'hF, 32'h0000_ABCD);
        send("b10_ch1_wrapn", 16'hFFF0, 2'd0, 1'b0, 1'b0, 4'hF, 32'h0001_FFE0);
        send("b11_ch0_mode3", 16'hABDD, 2'd3, 1'b0, 1'b0, 4'hF, 32'h0000_0010);
        send("b12_ch1_last",  16'h0000, 2'd2, 1'b1, 1'b0, 4'hA, 32'h0001_0000);
        send("b13_ch0_last",  16'hABDD, 2'd0, 1'b1, 1'b0, 4'h5, 32'h0000_0000);
        send("b14_ch0_again", 16'hABED, 2'd0, 1'b0, 1'b0, 4'hF, 32'h0000_0010);
        send("b15_ch1_clr",   16'h1234, 2'd0, 1'b0, 1'b1, 4'hF, 32'h0001_0000);
        send("b16_ch0_clred", 16'h0100, 2'd1, 1'b0, 1'b0, 4'hF, 32'h0000_0000);
        send("b17_ch1_kept",  16'h1244, 2'd0, 1'b0, 1'b0, 4'hF, 32'h0001_0010);

        @(posedge clk);
        #1;
        check_val("drain.valid", {31'd0, m_tvalid}, 32'd0);

        // Backpressure: beat A accepted, beat B waits while the sink stalls.
        @(negedge clk);
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = {16'h0200, 16'h0000};
        mode     = 2'd0;
        s_tstrb  = 4'hF;
        @(posedge clk);
        #1;
        check_val("bp.a_data", m_tdata, 32'h0000_0100);
        s_tdata = {16'h1254, 16'h0000};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_val("bp.hold_data", m_tdata, 32'h0000_0100);
            check_val("bp.hold_valid", {31'd0, m_tvalid}, 32'd1);
            check_val("bp.s_ready_low", {31'd0, s_tready}, 32'd0);
        end
        @(negedge clk);
        m_tready = 1'b1;
        #1;
        check_val("bp.s_ready_high", {31'd0, s_tready}, 32'd1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        check_val("bp.b_data", m_tdata, 32'h0001_0010);
        @(posedge clk);
        #1;
        check_val("bp.drain", {31'd0, m_tvalid}, 32'd0);

        // Async reset while an output beat is stalled.
        @(negedge clk);
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = {16'h0300, 16'h0000};
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        check_val("ar.pending", m_tdata, 32'h0000_0100);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("ar.valid_drop", {31'd0, m_tvalid}, 32'd0);
        check_val("ar.data_clr", m_tdata, 32'h0000_0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send("ar_first_ch0", 16'h4444, 2'd0, 1'b0, 1'b0, 4'hF, 32'h0000_0000);
        send("ar_first_ch1", 16'h5555, 2'd0, 1'b0, 1'b0, 4'hF, 32'h0001_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
